hazard_unit_mc: RTL

//  Parametrised hazard unit for the 5-stage pipeline: forwarding, load-use interlock, branch flush,

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/mdu_stall_ctrl.sv | 80 ++++++++
 rtl/hazard_unit_mc.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_pkg
// Brief  : Shared encodings for the pipeline hazard unit: forwarding-mux
//          select codes and the multi-cycle MDU controller state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    // Forwarding mux selects for the EX-stage ALU operands
    localparam logic [1:0] FWD_RF  = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // operand from WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // operand from MEM ALU result

    // MDU hold controller states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mduState_t;

endpackage
`default_nettype wire

// File: rtl/mdu_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mdu_stall_ctrl
// Brief  : Holds a multi-cycle mul/div op in EX for exactly MDU_LAT cycles.
//          The op stalls the front of the pipe in its first cycle (IDLE with
//          MduStartE) and every BUSY cycle; the DONE cycle releases the pipe
//          while the result is valid in EX.
// Ports  : clk, rst_n      clock / async active-low reset
//          MduStartE       EX instruction is an MDU op
//          PCSrcE          taken branch in EX (aborts a BUSY op defensively)
//          mduStall        hold request for IF/ID/EX
//          MduBusy         controller not idle
//          MduDone         final MDU cycle
// Rev    : 1.0  initial release
// ============================================================================
module mdu_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MduStartE,
    input  logic PCSrcE,
    output logic mduStall,
    output logic MduBusy,
    output logic MduDone
);

    localparam int CNT_W = $clog2(MDU_LAT) + 1;
    // First and last cycles are IDLE and DONE, so BUSY covers MDU_LAT-2 cycles
    localparam logic [CNT_W-1:0] c_CNT_INIT = CNT_W'(MDU_LAT - 2);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    mduState_t        r_state;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (MduStartE) begin
                        if (MDU_LAT == 2) begin
                            r_state <= MDU_DONE;
                        end else begin
                            r_state <= MDU_BUSY;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                MDU_BUSY: begin
                    // A taken branch cannot legally resolve while EX is held;
                    // if it does, drop the op rather than wedge the pipe.
                    if (PCSrcE) begin
                        r_state <= MDU_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                        if (r_cnt == c_CNT_ONE) begin
                            r_state <= MDU_DONE;
                        end
                    end
                end
                // The op still sits in EX during DONE; its MduStartE must not
                // be taken as a new op.
                MDU_DONE: r_state <= MDU_IDLE;
                default:  r_state <= MDU_IDLE;
            endcase
        end
    end

    assign mduStall = ((r_state == MDU_IDLE) && MduStartE) || (r_state == MDU_BUSY);
    assign MduBusy  = (r_state != MDU_IDLE);
    assign MduDone  = (r_state == MDU_DONE);

endmodule
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module : hazard_unit_mc
// Brief  : Hazard unit for the 5-stage pipeline. Operand forwarding,
//          load-use interlock (or full RAW interlock when FWD_EN=0), branch
//          flush, multi-cycle MDU hold, and a saturating stall-cycle counter.
// Ports  : clk, rst_n                 clock / async active-low reset
//          rs1D, rs2D, rs1E, rs2E     ID / EX source registers
//          rdE, rdM, rdW              EX / MEM / WB destination registers
//          RegWriteE/M/W              stage writes rd
//          ResultSrcE                 EX instruction is a load
//          PCSrcE                     taken branch/jump resolved in EX
//          MduStartE                  EX instruction is an MDU op
//          StallF, StallD, StallE     hold PC / IF-ID / ID-EX
//          FlushD, FlushE, FlushM     bubble IF-ID / ID-EX / EX-MEM
//          ForwardAE, ForwardBE       00 regfile, 01 WB, 10 MEM
//          MduBusy, MduDone           MDU controller status
//          stall_cycles               saturating count of StallF cycles
// Rev    : 1.0  initial release
// ============================================================================
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MDU_LAT     = 4,
    parameter int FWD_EN      = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_AW-1:0]      rs1D,
    input  logic [REG_AW-1:0]      rs2D,
    input  logic [REG_AW-1:0]      rs1E,
    input  logic [REG_AW-1:0]      rs2E,
    input  logic [REG_AW-1:0]      rdE,
    input  logic [REG_AW-1:0]      rdM,
    input  logic [REG_AW-1:0]      rdW,
    input  logic                   RegWriteE,
    input  logic                   RegWriteM,
    input  logic                   RegWriteW,
    input  logic                   ResultSrcE,
    input  logic                   PCSrcE,
    input  logic                   MduStartE,
    output logic                   StallF,
    output logic                   StallD,
    output logic                   StallE,
    output logic                   FlushD,
    output logic                   FlushE,
    output logic                   FlushM,
    output logic [1:0]             ForwardAE,
    output logic [1:0]             ForwardBE,
    output logic                   MduBusy,
    output logic                   MduDone,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    // x0 is hardwired to zero, so it never carries a dependency
    function automatic logic regMatch(input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b,
                                      input logic              we);
        return we && (b != '0) && (a == b);
    endfunction

    logic [1:0] w_fwdA;
    logic [1:0] w_fwdB;
    logic       w_lwHaz;
    logic       w_rawHaz;
    logic       w_lwStall;
    logic       w_rawStall;
    logic       w_mduStall;
    logic       w_hazStall;

    // MEM is the younger producer, so it wins over WB
    assign w_fwdA = regMatch(rs1E, rdM, RegWriteM) ? FWD_MEM :
                    regMatch(rs1E, rdW, RegWriteW) ? FWD_WB  : FWD_RF;
    assign w_fwdB = regMatch(rs2E, rdM, RegWriteM) ? FWD_MEM :
                    regMatch(rs2E, rdW, RegWriteW) ? FWD_WB  : FWD_RF;

    assign w_lwHaz  = ResultSrcE && (regMatch(rs1D, rdE, 1'b1) || regMatch(rs2D, rdE, 1'b1));
    // Without forwarding, any pending EX or MEM write blocks ID; WB is safe
    // because the register file writes before it reads.
    assign w_rawHaz = regMatch(rs1D, rdE, RegWriteE) || regMatch(rs2D, rdE, RegWriteE) ||
                      regMatch(rs1D, rdM, RegWriteM) || regMatch(rs2D, rdM, RegWriteM);

    assign ForwardAE  = (FWD_EN != 0) ? w_fwdA  : FWD_RF;
    assign ForwardBE  = (FWD_EN != 0) ? w_fwdB  : FWD_RF;
    assign w_lwStall  = (FWD_EN != 0) ? w_lwHaz : 1'b0;
    assign w_rawStall = (FWD_EN == 0) ? w_rawHaz : 1'b0;

    generate
        if (MDU_LAT >= 2) begin : g_mdu
            mdu_stall_ctrl #(
                .MDU_LAT (MDU_LAT)
            ) u_mduCtrl (
                .clk       (clk),
                .rst_n     (rst_n),
                .MduStartE (MduStartE),
                .PCSrcE    (PCSrcE),
                .mduStall  (w_mduStall),
                .MduBusy   (MduBusy),
                .MduDone   (MduDone)
            );
        end else begin : g_noMdu
            logic w_unusedMduStart;
            assign w_unusedMduStart = MduStartE;
            assign w_mduStall       = 1'b0;
            assign MduBusy          = 1'b0;
            assign MduDone          = 1'b0;
        end
    endgenerate

    assign w_hazStall = w_lwStall || w_rawStall;

    assign StallF = w_hazStall || w_mduStall;
    assign StallD = StallF;
    assign StallE = w_mduStall;
    assign FlushM = w_mduStall;
    // A held EX stage must keep its contents, so hold overrides flush
    assign FlushD = PCSrcE && !w_mduStall;
    assign FlushE = (w_hazStall || PCSrcE) && !w_mduStall;

    logic [STALL_CNT_W-1:0] r_stallCycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCycles <= '0;
        end else if (StallF && (r_stallCycles != '1)) begin
            r_stallCycles <= r_stallCycles + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stallCycles;

endmodule
`default_nettype wire
